// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out reader: Avalon-MM burst-read master that fetches one frame
// into a pixel FIFO and hands pixels to the LCD stage one per request.
//
// state | meaning
// IDLE  | reset state, waiting for the first frame start
// REQ   | burst request pending (or waiting for FIFO room to issue one)
// WAIT  | burst accepted, collecting beats into the FIFO
// DONE  | whole frame fetched, waiting for the next frame start
// DRAIN | frame restarted mid-burst, discarding the rest of the burst
module fb_scanout_reader #(
   parameter logic [31:0] FB_BASE    = 32'h2000_0000,
   parameter int          H_RES      = 800,
   parameter int          V_RES      = 480,
   parameter int          BURST_LEN  = 8,
   parameter int          FIFO_DEPTH = 64
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iFrameStart,
   input  logic        avl_waitrequest,
   output logic [31:0] avl_address,
   output logic        avl_read,
   output logic        avl_burstbegin,
   output logic [4:0]  avl_burstcount,
   input  logic        avl_readdatavalid,
   input  logic [31:0] avl_readdata,
   output logic        avl_write,
   output logic [31:0] avl_writedata,
   input  logic        iPixelReq,
   output logic [23:0] oPixel,
   output logic        oPixelValid,
   output logic        oUnderflow,
   output logic        oFrameDone
);

   localparam int          PW          = $clog2(FIFO_DEPTH);
   localparam logic [18:0] TOTAL_WORDS = 19'(H_RES * V_RES);
   localparam logic [18:0] WORD_STEP   = 19'(BURST_LEN);
   localparam logic [31:0] ADDR_STEP   = 32'(BURST_LEN * 4);
   localparam logic [4:0]  LAST_BEAT   = 5'(BURST_LEN - 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

   state_t      state;
   logic [18:0] word_cnt;
   logic [18:0] word_next;
   logic [4:0]  beat_cnt;
   logic        restart_pending;
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [PW:0] fifo_count;
   logic        fifo_empty;
   logic        fifo_full;
   logic        space_ok;
   logic        beat_last;
   logic        restart;
   logic        push;
   logic        pop;
   logic [23:0] fifo_mem [FIFO_DEPTH];
   logic        data_unused;

   assign avl_burstcount = 5'(BURST_LEN);
   assign avl_write      = 1'b0;
   assign avl_writedata  = '0;
   assign data_unused    = &{1'b0, avl_readdata[31:24]};

   always_comb begin
      fifo_count = wr_ptr - rd_ptr;
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
      space_ok   = (32'(fifo_count) <= 32'(FIFO_DEPTH - BURST_LEN));
      beat_last  = avl_readdatavalid && (beat_cnt == LAST_BEAT);
      word_next  = word_cnt + WORD_STEP;
      // A restart needs no burst in flight; mid-burst starts are deferred to DRAIN's end.
      restart = 1'b0;
      case (state)
         IDLE, DONE: restart = iFrameStart;
         REQ:        restart = iFrameStart && !avl_read;
         WAIT:       restart = iFrameStart && beat_last;
         DRAIN:      restart = beat_last;
         default:    restart = 1'b0;
      endcase
      push = (state == WAIT) && avl_readdatavalid && !restart && !fifo_full;
      pop  = iPixelReq && !fifo_empty && !restart;
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state           <= IDLE;
         avl_read        <= 1'b0;
         avl_burstbegin  <= 1'b0;
         avl_address     <= FB_BASE;
         word_cnt        <= '0;
         beat_cnt        <= '0;
         restart_pending <= 1'b0;
         oFrameDone      <= 1'b0;
      end else if (restart) begin
         state           <= REQ;
         avl_read        <= 1'b1;
         avl_burstbegin  <= 1'b1;
         avl_address     <= FB_BASE;
         word_cnt        <= '0;
         beat_cnt        <= '0;
         restart_pending <= 1'b0;
         oFrameDone      <= 1'b0;
      end else begin
         case (state)
            REQ: begin
               if (avl_read) begin
                  if (iFrameStart) restart_pending <= 1'b1;
                  if (!avl_waitrequest) begin
                     avl_read        <= 1'b0;
                     avl_burstbegin  <= 1'b0;
                     beat_cnt        <= '0;
                     restart_pending <= 1'b0;
                     state           <= (restart_pending || iFrameStart) ? DRAIN : WAIT;
                  end
               end else if (space_ok) begin
                  avl_read       <= 1'b1;
                  avl_burstbegin <= 1'b1;
               end
            end
            WAIT: begin
               if (avl_readdatavalid) beat_cnt <= beat_cnt + 5'd1;
               if (iFrameStart) begin
                  state <= DRAIN;
               end else if (beat_last) begin
                  avl_address <= avl_address + ADDR_STEP;
                  word_cnt    <= word_next;
                  if (word_next == TOTAL_WORDS) begin
                     state      <= DONE;
                     oFrameDone <= 1'b1;
                  end else begin
                     state <= REQ;
                  end
               end
            end
            DRAIN: begin
               if (avl_readdatavalid) beat_cnt <= beat_cnt + 5'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         oUnderflow  <= 1'b0;
      end else if (restart) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         oUnderflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (iPixelReq && fifo_empty) oUnderflow <= 1'b1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= avl_readdata[23:0];
   end

   assign oPixelValid = !fifo_empty;
   assign oPixel      = fifo_empty ? 24'h0 : fifo_mem[rd_ptr[PW-1:0]];

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: cycle tables for single burst, underflow and restarts,
// plus an automatic memory/consumer model for a reduced 32x4 frame and backpressure.
module tb_fb_scanout_reader;

   localparam logic [31:0] A0 = 32'h2000_0000;

   logic        iCLK = 1'b0;
   logic        iRST_n = 1'b0;
   logic        fs = 1'b0;
   logic        wr = 1'b0;
   logic        dv = 1'b0;
   logic [31:0] d = '0;
   logic        pr = 1'b0;
   logic [31:0] avl_address;
   logic        avl_read;
   logic        avl_burstbegin;
   logic [4:0]  avl_burstcount;
   logic        avl_write;
   logic [31:0] avl_writedata;
   logic [23:0] oPixel;
   logic        oPixelValid;
   logic        oUnderflow;
   logic        oFrameDone;

   int total = 0;
   int bad = 0;

   int beats_left, bursts, wi, exp_pix, occ, occ_prev;
   logic        prev_read;
   logic [31:0] last_addr;

   always #5 iCLK = ~iCLK;

   fb_scanout_reader #(
      .FB_BASE(A0), .H_RES(32), .V_RES(4), .BURST_LEN(8), .FIFO_DEPTH(64)
   ) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .iFrameStart(fs), .avl_waitrequest(wr),
      .avl_address(avl_address), .avl_read(avl_read), .avl_burstbegin(avl_burstbegin),
      .avl_burstcount(avl_burstcount), .avl_readdatavalid(dv), .avl_readdata(d),
      .avl_write(avl_write), .avl_writedata(avl_writedata), .iPixelReq(pr),
      .oPixel(oPixel), .oPixelValid(oPixelValid), .oUnderflow(oUnderflow),
      .oFrameDone(oFrameDone)
   );

   typedef struct {
      bit          rst;
      string       name;
      bit          fs, wr, dv;
      logic [31:0] d;
      bit          pr;
      bit          e_rd, e_bb;
      logic [31:0] e_addr;
      bit          e_pv;
      logic [23:0] e_pix;
      bit          e_uf, e_fd;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, string name, bit vfs, bit vwr, bit vdv, logic [31:0] vd,
                               bit vpr, bit e_rd, bit e_bb, logic [31:0] e_addr, bit e_pv,
                               logic [23:0] e_pix, bit e_uf, bit e_fd);
      vec_t t;
      t.rst = rst; t.name = name; t.fs = vfs; t.wr = vwr; t.dv = vdv; t.d = vd; t.pr = vpr;
      t.e_rd = e_rd; t.e_bb = e_bb; t.e_addr = e_addr; t.e_pv = e_pv; t.e_pix = e_pix;
      t.e_uf = e_uf; t.e_fd = e_fd;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge iCLK);
      iRST_n = 1'b0; fs = 1'b0; wr = 1'b0; dv = 1'b0; d = '0; pr = 1'b0;
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      iRST_n = 1'b1;
   endtask

   task automatic start_frame();
      fs = 1'b1;
      @(posedge iCLK);
      @(negedge iCLK);
      fs = 1'b0;
   endtask

   task automatic reset_model();
      beats_left = 0; bursts = 0; wi = 0; exp_pix = 0; occ = 0; occ_prev = 0;
      prev_read = 1'b0; last_addr = '0;
   endtask

   // Slave returns data = word index; consumer pops whenever a pixel is valid.
   task automatic run_auto(input int cycles, input bit consume, input bit until_done);
      bit accept;
      for (int c = 0; c < cycles; c++) begin
         if (until_done && oFrameDone && occ == 0) break;
         wr = ((c % 7) == 3);
         dv = (beats_left > 0);
         d  = 32'(wi);
         pr = consume && oPixelValid;
         if (pr) begin
            check("pix_order", 64'(oPixel), 64'(24'(exp_pix)));
            exp_pix++;
         end
         if (avl_read && !prev_read) check("req_space", 64'(occ_prev <= 56), 64'd1);
         accept = avl_read && !wr;
         if (accept) begin
            check("burst_addr", 64'(avl_address), 64'(A0 + 32'(bursts * 32)));
            last_addr = avl_address;
            bursts++;
         end
         prev_read = avl_read;
         occ_prev  = occ;
         occ       = occ + (dv ? 1 : 0) - (pr ? 1 : 0);
         if (dv) begin
            beats_left--;
            wi++;
         end
         @(posedge iCLK);
         @(negedge iCLK);
         if (accept) beats_left = 8;
      end
      dv = 1'b0; pr = 1'b0; wr = 1'b0;
   endtask

   initial begin
      // single burst with 3 stall cycles, continuous consumer once data flows
      add(1, "sb", 1, 1, 0, 0, 0, 1, 1, A0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) add(0, "sb", 0, 1, 0, 0, 0, 1, 1, A0, 0, 0, 0, 0);
      add(0, "sb", 0, 0, 0, 0, 0, 0, 0, A0, 0, 0, 0, 0);
      add(0, "sb", 0, 0, 1, 32'd1, 0, 0, 0, A0, 1, 24'd1, 0, 0);
      for (int k = 2; k <= 7; k++) add(0, "sb", 0, 0, 1, 32'(k), 1, 0, 0, A0, 1, 24'(k), 0, 0);
      add(0, "sb", 0, 0, 1, 32'd8, 1, 0, 0, A0 + 32'h20, 1, 24'd8, 0, 0);
      add(0, "sb", 0, 0, 0, 0, 1, 1, 1, A0 + 32'h20, 0, 0, 0, 0);
      add(0, "sb", 0, 1, 0, 0, 0, 1, 1, A0 + 32'h20, 0, 0, 0, 0);

      // underflow, then restart while the request is still stalled
      add(1, "uf", 1, 1, 0, 0, 1, 1, 1, A0, 0, 0, 0, 0);
      add(0, "uf", 0, 1, 0, 0, 1, 1, 1, A0, 0, 0, 1, 0);
      add(0, "uf", 0, 1, 0, 0, 0, 1, 1, A0, 0, 0, 1, 0);
      add(0, "uf", 1, 1, 0, 0, 0, 1, 1, A0, 0, 0, 1, 0);
      add(0, "uf", 0, 0, 0, 0, 0, 0, 0, A0, 0, 0, 1, 0);
      for (int k = 0; k < 7; k++) add(0, "uf", 0, 0, 1, 32'h55, 1, 0, 0, A0, 0, 0, 1, 0);
      add(0, "uf", 0, 0, 1, 32'h55, 1, 1, 1, A0, 0, 0, 0, 0);
      add(0, "uf", 0, 1, 0, 0, 0, 1, 1, A0, 0, 0, 0, 0);

      // mid-burst restart on the second burst, second start absorbed in DRAIN
      add(1, "mr", 1, 0, 0, 0, 0, 1, 1, A0, 0, 0, 0, 0);
      add(0, "mr", 0, 0, 0, 0, 0, 0, 0, A0, 0, 0, 0, 0);
      for (int k = 1; k <= 7; k++)
         add(0, "mr", 0, 0, 1, 32'hFF00_0000 + 32'(k), 0, 0, 0, A0, 1, 24'd1, 0, 0);
      add(0, "mr", 0, 0, 1, 32'hFF00_0008, 0, 0, 0, A0 + 32'h20, 1, 24'd1, 0, 0);
      add(0, "mr", 0, 1, 0, 0, 0, 1, 1, A0 + 32'h20, 1, 24'd1, 0, 0);
      add(0, "mr", 0, 0, 0, 0, 0, 0, 0, A0 + 32'h20, 1, 24'd1, 0, 0);
      for (int k = 1; k <= 3; k++)
         add(0, "mr", 0, 0, 1, 32'h20 + 32'(k), 0, 0, 0, A0 + 32'h20, 1, 24'd1, 0, 0);
      add(0, "mr", 1, 0, 0, 0, 0, 0, 0, A0 + 32'h20, 1, 24'd1, 0, 0);
      add(0, "mr", 0, 0, 1, 32'h24, 0, 0, 0, A0 + 32'h20, 1, 24'd1, 0, 0);
      add(0, "mr", 1, 0, 1, 32'h25, 0, 0, 0, A0 + 32'h20, 1, 24'd1, 0, 0);
      add(0, "mr", 0, 0, 1, 32'h26, 0, 0, 0, A0 + 32'h20, 1, 24'd1, 0, 0);
      add(0, "mr", 0, 0, 1, 32'h27, 0, 0, 0, A0 + 32'h20, 1, 24'd1, 0, 0);
      add(0, "mr", 0, 0, 1, 32'h28, 1, 1, 1, A0, 0, 0, 0, 0);
      add(0, "mr", 0, 0, 0, 0, 0, 0, 0, A0, 0, 0, 0, 0);
      add(0, "mr", 0, 0, 1, 32'h77, 0, 0, 0, A0, 1, 24'h77, 0, 0);

      // reset values held for 100 cycles
      do_reset();
      check("tie_off", 64'({avl_write, avl_writedata, avl_burstcount}), 64'({1'b0, 32'h0, 5'd8}));
      for (int i = 0; i < 100; i++) begin
         check("rst_hold",
               64'({avl_read, avl_burstbegin, avl_address, oPixelValid, oPixel, oUnderflow, oFrameDone}),
               64'({1'b0, 1'b0, A0, 1'b0, 24'h0, 1'b0, 1'b0}));
         @(negedge iCLK);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         fs = vecs[i].fs; wr = vecs[i].wr; dv = vecs[i].dv; d = vecs[i].d; pr = vecs[i].pr;
         @(posedge iCLK);
         #1;
         check($sformatf("%s[%0d]", vecs[i].name, i),
               64'({avl_read, avl_burstbegin, avl_address, oPixelValid, oPixel, oUnderflow, oFrameDone}),
               64'({vecs[i].e_rd, vecs[i].e_bb, vecs[i].e_addr, vecs[i].e_pv, vecs[i].e_pix,
                    vecs[i].e_uf, vecs[i].e_fd}));
         @(negedge iCLK);
      end
      fs = 1'b0; wr = 1'b0; dv = 1'b0; d = '0; pr = 1'b0;

      // full (reduced) frame: 128 words = 16 bursts
      do_reset();
      reset_model();
      start_frame();
      run_auto(3000, 1'b1, 1'b1);
      check("frame_done", 64'(oFrameDone), 64'd1);
      check("frame_bursts", 64'(bursts), 64'd16);
      check("frame_last_addr", 64'(last_addr), 64'h2000_01E0);
      check("frame_pixels", 64'(exp_pix), 64'd128);
      check("frame_underflow", 64'(oUnderflow), 64'd0);
      check("frame_idle", 64'({avl_read, oPixelValid}), 64'd0);
      start_frame();
      check("done_restart", 64'({avl_read, avl_address, oFrameDone}), 64'({1'b1, A0, 1'b0}));

      // backpressure: no consumer, then release
      do_reset();
      reset_model();
      start_frame();
      run_auto(200, 1'b0, 1'b0);
      check("bp_bursts", 64'(bursts), 64'd8);
      check("bp_occ", 64'(occ), 64'd64);
      check("bp_stalled", 64'({avl_read, oPixelValid, oPixel}), 64'({1'b0, 1'b1, 24'd0}));
      run_auto(40, 1'b1, 1'b0);
      check("bp_resume", 64'(bursts > 8), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fb_scanout_reader.md
# fb_scanout_reader

Framebuffer scan-out reader for the MTL display path. It is an Avalon-MM burst-read master that fetches the 800×480, 32-bit-per-pixel frame that the rectangle painter writes at 0x20000000. It buffers the fetched pixels in an internal FIFO and presents them one per request to the LCD timing/pixel stage. It sits between SDRAM (through the Avalon interconnect) and the display timing generator, in the iCLK domain.

## Interface

**Parameters**
- FB_BASE, 32'h20000000: byte address of pixel (0,0).
- H_RES, 800: pixels per line.
- V_RES, 480: lines per frame.
- BURST_LEN, 8: words per read burst, range 1..16. H_RES*V_RES must be a multiple of BURST_LEN.
- FIFO_DEPTH, 64: pixel FIFO entries, power of 2, ≥ 2*BURST_LEN.

**Ports**
- iCLK, input, 1: clock.
- iRST_n, input, 1: asynchronous, active-low reset.
- iFrameStart, input, 1: one-cycle pulse at the start of vertical blank; restarts the fetch at FB_BASE.
- avl_waitrequest, input, 1: slave stall.
- avl_address, output, 32: byte address of the burst.
- avl_read, output, 1: read request.
- avl_burstbegin, output, 1: first cycle of a burst request.
- avl_burstcount, output, 5: constant BURST_LEN.
- avl_readdatavalid, input, 1: read beat valid.
- avl_readdata, input, 32: read beat, format 0x00RRGGBB.
- avl_write, output, 1: tied 0.
- avl_writedata, output, 32: tied 0.
- iPixelReq, input, 1: display consumes the head pixel this cycle.
- oPixel, output, 24: FIFO head, {R,G,B}.
- oPixelValid, output, 1: FIFO not empty.
- oUnderflow, output, 1: sticky; iPixelReq was seen while the FIFO was empty.
- oFrameDone, output, 1: all H_RES*V_RES words of the current frame have been requested and received.

## Operation

**States:** IDLE, REQ, WAIT, DONE, DRAIN.

**IDLE**
- Waits for iFrameStart.
- On iFrameStart: word counter ← 0, avl_address ← FB_BASE, FIFO flushed, oUnderflow ← 0, go to REQ.

**REQ**
- Enters only when FIFO free space ≥ BURST_LEN. Otherwise it holds with avl_read = 0 until space is available.
- Drives avl_read = 1 and avl_burstbegin = 1, and holds both with a stable address until sampled with avl_waitrequest = 0.
- On acceptance: go to WAIT.

**WAIT**
- Each avl_readdatavalid pushes avl_readdata[23:0] into the FIFO and increments the beat counter.
- After BURST_LEN beats:
  - avl_address += BURST_LEN*4 and the word counter += BURST_LEN.
  - If the word counter equals H_RES*V_RES, go to DONE; otherwise go to REQ.
- Only one burst is outstanding at a time.

**DONE**
- oFrameDone = 1.
- On iFrameStart: restart exactly as from IDLE.

**Restart during a frame**
- iFrameStart in REQ or WAIT sets restart_pending.
- In REQ, the request is held until accepted; the machine then enters DRAIN.
- In WAIT, the machine enters DRAIN immediately.
- DRAIN discards the remaining beats of the burst, with no FIFO push.
- When the beat count completes, the restart is performed as from IDLE.
- A second iFrameStart during DRAIN is absorbed and does not cause a double restart.

**Pixel output**
- oPixelValid = !empty and oPixel = head.
- iPixelReq && !empty pops the FIFO.
- iPixelReq && empty sets oUnderflow. No pop occurs.
- oUnderflow clears only on a restart or on reset.

**Simultaneous events**
- A FIFO push and pop in the same cycle both take effect, and the occupancy is unchanged.
- A restart flush takes priority over a same-cycle pop or push.

**Arithmetic**
- Word counter is 19 bits (H_RES*V_RES = 384000).
- Address increments wrap modulo 2^32.
- FIFO pointers have log2(FIFO_DEPTH)+1 bits. Full is indicated by the MSB differing while the remaining bits are equal.

## Timing

**Reset values**
- State = IDLE.
- avl_read = 0, avl_burstbegin = 0, avl_address = FB_BASE.
- oPixel = 0, oPixelValid = 0, oUnderflow = 0, oFrameDone = 0.
- FIFO is empty.

**Reset mid-burst**
- Outstanding beats are abandoned. The interconnect is reset with iRST_n.

**Latencies**
- iFrameStart → avl_read high: 1 cycle (registered).
- A beat with avl_readdatavalid in cycle N → oPixelValid high in N+1 (registered FIFO write, combinational read of the head).
- Pop → next head visible the following cycle.

**Output registering**
- avl_read, avl_burstbegin and avl_address are registered.
- avl_burstbegin is high only while a request is pending in REQ.

## Test plan

1. **Reset:** release iRST_n with no iFrameStart → all outputs hold their reset values for 100 cycles; avl_read = 0.
2. **Single burst:**
   - Stimulus: iFrameStart, with 3 cycles of waitrequest.
   - Required: avl_address = 0x20000000 is held stable with avl_read/avl_burstbegin high until accepted.
   - Stimulus: return 8 beats 0x00000001..0x00000008.
   - Required: oPixel = 1..8 in order under a continuous iPixelReq. The next request address is 0x20000020.
3. **Full frame:**
   - Stimulus: memory model returns data = word index; consumer always requests when valid.
   - Required: exactly 48000 bursts, oFrameDone = 1, last address 0x20176FE0, oUnderflow = 0.
4. **Backpressure:**
   - Stimulus: hold iPixelReq = 0.
   - Required: requests stop once 64 pixels are buffered and never overflow. Releasing iPixelReq resumes requests once 8 entries are free.
5. **Underflow:**
   - Stimulus: iPixelReq = 1 before any data arrives.
   - Required: oUnderflow = 1 and stays set until the next iFrameStart, then clears.
6. **Mid-burst restart:**
   - Stimulus: iFrameStart after 3 of 8 beats.
   - Required: the remaining 5 beats are discarded, the FIFO is empty, and the next request address is 0x20000000.
